// File: rtl/sdi_xcvr_link_supervisor.sv
// ---------------------------------------------------------------------------
// sdi_xcvr_link_supervisor
//
// Purpose:
//   Drives the `reset` input of the Stratix 10 transceiver reset controller
//   for the SDI link. It brings the link up, times out bring-ups that fail,
//   and restarts the reset sequence after a back-off when lock is lost,
//   when a ready drops, or when software asks for it.
//
// Optional feature (compile-time macro):
//   SDI_XCVR_SUP_RETRY_LIMIT_EN
//     defined   : MAX_RETRIES consecutive bring-up timeouts park the link in
//                 FAULT (fault=1, ctrl_reset=1) until kick or enable=0.
//     undefined : FAULT is unreachable, fault is tied 0 and retries go on
//                 indefinitely.
//
// Ports:
//   clock               in   system clock, shared with the reset controller
//   reset               in   synchronous, active-high reset
//   enable              in   level, link operation permitted
//   kick                in   single-cycle software relink request
//   tx_ready            in   reset controller tx ready (clock domain)
//   rx_ready            in   reset controller rx ready (clock domain)
//   rx_is_lockedtodata  in   CDR lock, asynchronous (2-flop synchronised)
//   ctrl_reset          out  to the reset controller `reset` input
//   link_up             out  high only in UP
//   relink_pulse        out  one-cycle pulse on each UP->BACKOFF transition
//   retry_count   [3:0] out  consecutive bring-up timeouts, saturating at 15
//   sup_state     [2:0] out  IDLE=0 HOLD=1 WAIT_RDY=2 UP=3 BACKOFF=4 FAULT=5
//   fault               out  high in FAULT
// ---------------------------------------------------------------------------
module sdi_xcvr_link_supervisor #(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int READY_TIMEOUT   = 1000000,
  parameter int LOL_DEBOUNCE    = 64,
  parameter int BACKOFF_CYCLES  = 1024,
  parameter int MAX_RETRIES     = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       kick,
  input  logic       tx_ready,
  input  logic       rx_ready,
  input  logic       rx_is_lockedtodata,
  output logic       ctrl_reset,
  output logic       link_up,
  output logic       relink_pulse,
  output logic [3:0] retry_count,
  output logic [2:0] sup_state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HOLD     = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_UP       = 3'd3,
    S_BACKOFF  = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  // Down-counter load values: a load of N-1 followed by "leave at 0"
  // keeps the state for exactly N cycles.
  localparam logic [23:0] LP_HOLD_LD = 24'(RST_HOLD_CYCLES - 1);
  localparam logic [23:0] LP_WAIT_LD = 24'(READY_TIMEOUT - 1);
  localparam logic [23:0] LP_BO_LD   = 24'(BACKOFF_CYCLES - 1);
  localparam logic [23:0] LP_LOL_MAX = 24'(LOL_DEBOUNCE);

  // Reject out-of-range parameters at elaboration.
  if (RST_HOLD_CYCLES < 1 || RST_HOLD_CYCLES > 16777215 ||
      READY_TIMEOUT   < 1 || READY_TIMEOUT   > 16777215 ||
      LOL_DEBOUNCE    < 1 || LOL_DEBOUNCE    > 16777215 ||
      BACKOFF_CYCLES  < 1 || BACKOFF_CYCLES  > 16777215 ||
      MAX_RETRIES     < 1 || MAX_RETRIES     > 15) begin : g_bad_param
    $error("sdi_xcvr_link_supervisor: parameter out of range");
  end

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic        r_lock_meta;
  logic        r_lock_sync;
  state_t      r_state;
  logic [23:0] r_cnt;
  logic [23:0] r_dbnc;
  logic        r_ctrl_reset;
  logic        r_link_up;
  logic        r_relink;
  logic [3:0]  r_retry;

  logic [3:0]  w_retry_next;
  logic        w_limit_hit;
  logic        w_lol;
  logic        w_up_exit;

  // ---- lock synchroniser ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= rx_is_lockedtodata;
      r_lock_sync <= r_lock_meta;
    end
  end

  assign w_retry_next = sat_inc(r_retry);

`ifdef SDI_XCVR_SUP_RETRY_LIMIT_EN
  logic r_fault;
  // >= rather than == so a retry count held across an enable=0 episode
  // still lands in FAULT on its next timeout.
  assign w_limit_hit = (w_retry_next >= 4'(MAX_RETRIES));
  assign fault       = r_fault;
`else
  assign w_limit_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  // The debounce count is compared in its registered form, which gives the
  // 2 + LOL_DEBOUNCE + 1 cycle detection latency from a lock drop.
  assign w_lol     = (r_dbnc == LP_LOL_MAX);
  assign w_up_exit = ~tx_ready | ~rx_ready | kick | w_lol;

  // ---- supervisor FSM, all outputs registered with the state ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dbnc       <= '0;
      r_ctrl_reset <= 1'b1;
      r_link_up    <= 1'b0;
      r_relink     <= 1'b0;
      r_retry      <= 4'd0;
`ifdef SDI_XCVR_SUP_RETRY_LIMIT_EN
      r_fault      <= 1'b0;
`endif
    end else begin
      r_relink <= 1'b0;
      // Debounce only accumulates while UP; every other path clears it.
      r_dbnc   <= '0;
      if (!enable) begin
        // enable=0 overrides every transition; retry_count is kept.
        r_state      <= S_IDLE;
        r_ctrl_reset <= 1'b1;
        r_link_up    <= 1'b0;
`ifdef SDI_XCVR_SUP_RETRY_LIMIT_EN
        r_fault      <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state      <= S_HOLD;
            r_cnt        <= LP_HOLD_LD;
            r_ctrl_reset <= 1'b1;
          end

          S_HOLD: begin
            if (r_cnt == '0) begin
              r_state      <= S_WAIT_RDY;
              r_cnt        <= LP_WAIT_LD;
              r_ctrl_reset <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end

          S_WAIT_RDY: begin
            // Readiness is checked first so it wins over a same-cycle timeout.
            if (tx_ready && rx_ready) begin
              r_state   <= S_UP;
              r_link_up <= 1'b1;
              r_retry   <= 4'd0;
            end else if (kick) begin
              r_state      <= S_BACKOFF;
              r_cnt        <= LP_BO_LD;
              r_ctrl_reset <= 1'b1;
            end else if (r_cnt == '0) begin
              r_retry      <= w_retry_next;
              r_ctrl_reset <= 1'b1;
              if (w_limit_hit) begin
                r_state <= S_FAULT;
`ifdef SDI_XCVR_SUP_RETRY_LIMIT_EN
                r_fault <= 1'b1;
`endif
              end else begin
                r_state <= S_BACKOFF;
                r_cnt   <= LP_BO_LD;
              end
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end

          S_UP: begin
            if (w_up_exit) begin
              r_state      <= S_BACKOFF;
              r_cnt        <= LP_BO_LD;
              r_ctrl_reset <= 1'b1;
              r_link_up    <= 1'b0;
              r_relink     <= 1'b1;
            end else begin
              r_dbnc <= r_lock_sync ? 24'd0 : r_dbnc + 24'd1;
            end
          end

          S_BACKOFF: begin
            if (r_cnt == '0) begin
              r_state <= S_HOLD;
              r_cnt   <= LP_HOLD_LD;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end

          S_FAULT: begin
`ifdef SDI_XCVR_SUP_RETRY_LIMIT_EN
            if (kick) begin
              r_state <= S_HOLD;
              r_cnt   <= LP_HOLD_LD;
              r_retry <= 4'd0;
              r_fault <= 1'b0;
            end
`else
            // Unreachable without the retry limit; recover through IDLE.
            r_state      <= S_IDLE;
            r_ctrl_reset <= 1'b1;
`endif
          end

          default: begin
            r_state      <= S_IDLE;
            r_ctrl_reset <= 1'b1;
            r_link_up    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctrl_reset   = r_ctrl_reset;
  assign link_up      = r_link_up;
  assign relink_pulse = r_relink;
  assign retry_count  = r_retry;
  assign sup_state    = r_state;

endmodule

// File: tb/tb_sdi_xcvr_link_supervisor.sv
// ---------------------------------------------------------------------------
// Testbench for sdi_xcvr_link_supervisor.
// A table of {inputs, hold cycles, expected outputs} walks through bring-up,
// timeouts and the retry limit; hand sequences cover lock-loss debounce,
// ready/timeout collision, kick and enable drop; a randomized phase runs
// against a reference model that checks every cycle.
// ---------------------------------------------------------------------------
module tb_sdi_xcvr_link_supervisor;

  localparam int H  = 4;
  localparam int T  = 100;
  localparam int L  = 8;
  localparam int B  = 20;
  localparam int MR = 3;

`ifdef SDI_XCVR_SUP_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_HOLD = 1, M_WAIT = 2, M_UP = 3, M_BO = 4, M_FAULT = 5;

  logic       clk = 1'b0;
  logic       rst, en, kick, txr, rxr, lock;
  logic       ctrl_reset, link_up, relink_pulse, fault;
  logic [3:0] retry_count;
  logic [2:0] sup_state;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sdi_xcvr_link_supervisor #(
    .RST_HOLD_CYCLES(H), .READY_TIMEOUT(T), .LOL_DEBOUNCE(L),
    .BACKOFF_CYCLES(B), .MAX_RETRIES(MR)
  ) dut (
    .clock(clk), .reset(rst), .enable(en), .kick(kick),
    .tx_ready(txr), .rx_ready(rxr), .rx_is_lockedtodata(lock),
    .ctrl_reset(ctrl_reset), .link_up(link_up), .relink_pulse(relink_pulse),
    .retry_count(retry_count), .sup_state(sup_state), .fault(fault)
  );

  function automatic logic [10:0] dut_vec();
    return {sup_state, ctrl_reset, link_up, relink_pulse, retry_count, fault};
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {st,crst,up,rp,rc,flt}=%h required %h", nm, act, exp);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // ---- reference model: states with entry times and a lock sample window ----
  int m_st = M_IDLE;
  int m_retry = 0;
  bit m_relink = 1'b0;
  int cyc = 0;
  int t_in = 0;
  bit hist[$];

  initial for (int i = 0; i < L + 3; i++) hist.push_back(1'b0);

  always @(posedge clk) begin : ref_model
    bit lol;
    cyc++;
    m_relink = 1'b0;
    // Synchroniser flops are cleared by reset, so a reset edge feeds a 0.
    hist.push_back(rst ? 1'b0 : lock);
    void'(hist.pop_front());
    // Loss of lock: the raw samples taken 3..L+2 edges ago were all low,
    // and the link has been UP long enough for the debounce to have run.
    lol = (cyc - t_in >= L + 1);
    for (int k = 3; k <= L + 2; k++)
      if (hist[hist.size() - 1 - k]) lol = 1'b0;
    if (rst) begin
      m_st = M_IDLE; m_retry = 0; t_in = cyc;
    end else if (!en) begin
      m_st = M_IDLE; t_in = cyc;
    end else begin
      case (m_st)
        M_IDLE: begin m_st = M_HOLD; t_in = cyc; end
        M_HOLD: if (cyc - t_in == H) begin m_st = M_WAIT; t_in = cyc; end
        M_WAIT: begin
          if (txr && rxr) begin m_st = M_UP; m_retry = 0; t_in = cyc; end
          else if (kick) begin m_st = M_BO; t_in = cyc; end
          else if (cyc - t_in == T) begin
            m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
            m_st = (LIMIT_EN && m_retry >= MR) ? M_FAULT : M_BO;
            t_in = cyc;
          end
        end
        M_UP: if (!txr || !rxr || kick || lol) begin
          m_st = M_BO; m_relink = 1'b1; t_in = cyc;
        end
        M_BO: if (cyc - t_in == B) begin m_st = M_HOLD; t_in = cyc; end
        M_FAULT: if (kick) begin m_st = M_HOLD; m_retry = 0; t_in = cyc; end
        default: m_st = M_IDLE;
      endcase
    end
  end

  function automatic logic [10:0] model_vec();
    logic crst;
    crst = (m_st == M_IDLE) || (m_st == M_HOLD) || (m_st == M_BO) || (m_st == M_FAULT);
    return {3'(m_st), crst, (m_st == M_UP), m_relink, 4'(m_retry), (m_st == M_FAULT)};
  endfunction

  always @(negedge clk) if (chk_en) check("model", dut_vec(), model_vec());

  // ---- stimulus table ----
  typedef struct {
    bit rst, en, kick, rdy, lock;
    int ncyc;
    bit [2:0] st;
    bit cr, up, rp;
    bit [3:0] rc;
    bit flt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit k, bit rd, bit lk, int n,
                              bit [2:0] st, bit cr, bit up, bit rp, bit [3:0] rc, bit flt);
    vec_t v;
    v.rst = r; v.en = e; v.kick = k; v.rdy = rd; v.lock = lk; v.ncyc = n;
    v.st = st; v.cr = cr; v.up = up; v.rp = rp; v.rc = rc; v.flt = flt;
    return v;
  endfunction

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int k = 0;
    while (sup_state !== s && k < budget) begin @(negedge clk); k++; end
    checki(nm, int'(sup_state), int'(s));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; kick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    bit rdy_lvl;
    int burst;
    //            rst en kick rdy lock ncyc  st cr up rp rc flt
    tbl.push_back(mk(1, 1, 0, 0, 1,   2,   0, 1, 0, 0, 0, 0)); // reset
    tbl.push_back(mk(0, 1, 0, 0, 1,   1,   1, 1, 0, 0, 0, 0)); // HOLD entry
    tbl.push_back(mk(0, 1, 0, 0, 1,   3,   1, 1, 0, 0, 0, 0)); // still HOLD
    tbl.push_back(mk(0, 1, 0, 0, 1,   1,   2, 0, 0, 0, 0, 0)); // 4th: WAIT
    tbl.push_back(mk(0, 1, 0, 0, 1,   9,   2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1,   1,   3, 0, 1, 0, 0, 0)); // UP
    tbl.push_back(mk(0, 1, 1, 1, 1,   1,   4, 1, 0, 1, 0, 0)); // kick in UP
    tbl.push_back(mk(0, 1, 0, 0, 1,   1,   4, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,  18,   4, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1,   1, 1, 0, 0, 0, 0)); // 20th: HOLD
    tbl.push_back(mk(0, 1, 0, 0, 1,   4,   2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,  99,   2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1,   4, 1, 0, 0, 1, 0)); // timeout 1
    tbl.push_back(mk(0, 1, 0, 0, 1,  20,   1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,   4,   2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 100,   4, 1, 0, 0, 2, 0)); // timeout 2
    tbl.push_back(mk(0, 1, 0, 0, 1,  24,   2, 0, 0, 0, 2, 0));
`ifdef SDI_XCVR_SUP_RETRY_LIMIT_EN
    tbl.push_back(mk(0, 1, 0, 0, 1, 100,   5, 1, 0, 0, 3, 1)); // FAULT
    tbl.push_back(mk(0, 1, 1, 0, 1,   1,   1, 1, 0, 0, 0, 0)); // kick -> HOLD
    tbl.push_back(mk(0, 1, 0, 0, 1,   4,   2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,   1,   0, 1, 0, 0, 0, 0)); // enable off
`else
    tbl.push_back(mk(0, 1, 0, 0, 1, 100,   4, 1, 0, 0, 3, 0)); // no FAULT
    tbl.push_back(mk(0, 1, 1, 0, 1,   1,   4, 1, 0, 0, 3, 0)); // kick ignored
    tbl.push_back(mk(0, 1, 0, 0, 1,  19,   1, 1, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,   4,   2, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 100,   4, 1, 0, 0, 4, 0)); // timeout 4
    tbl.push_back(mk(0, 0, 0, 0, 1,   1,   0, 1, 0, 0, 4, 0)); // enable off
`endif

    rst = 1'b1; en = 1'b1; kick = 1'b0; txr = 1'b0; rxr = 1'b0; lock = 1'b1;
    fork
      begin @(negedge clk); chk_en = 1'b1; end
    join_none

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; en = tbl[i].en; kick = tbl[i].kick;
      txr = tbl[i].rdy; rxr = tbl[i].rdy; lock = tbl[i].lock;
      repeat (tbl[i].ncyc) @(negedge clk);
      check($sformatf("tbl%0d", i), dut_vec(),
            {tbl[i].st, tbl[i].cr, tbl[i].up, tbl[i].rp, tbl[i].rc, tbl[i].flt});
    end
    kick = 1'b0;

    // Lock loss debounce
    txr = 1'b1; rxr = 1'b1; lock = 1'b1;
    do_reset();
    wait_state(3'd3, 40, "s3_up");
    lock = 1'b0; repeat (7) @(negedge clk); lock = 1'b1;
    repeat (15) @(negedge clk);
    checki("short_drop_stays_up", int'(sup_state), 3);
    lock = 1'b0; k = 0;
    do begin @(negedge clk); k++; end while (sup_state !== 3'd4 && k < 40);
    checki("lol_latency", k, 11);
    checki("lol_relink", int'(relink_pulse), 1);
    checki("lol_link_up", int'(link_up), 0);
    lock = 1'b1; @(negedge clk);
    checki("lol_relink_single", int'(relink_pulse), 0);
    wait_state(3'd3, 60, "s3_reup");
    txr = 1'b0; @(negedge clk); txr = 1'b1;
    checki("txdrop_state", int'(sup_state), 4);
    checki("txdrop_relink", int'(relink_pulse), 1);

    // Ready and timeout in the same cycle, kick in UP, enable drop in HOLD
    txr = 1'b0; rxr = 1'b0;
    do_reset();
    wait_state(3'd2, 20, "s4_wait");
    repeat (99) @(negedge clk);
    checki("pre_timeout_state", int'(sup_state), 2);
    txr = 1'b1; rxr = 1'b1; @(negedge clk);
    checki("rdy_beats_timeout", int'(sup_state), 3);
    checki("rdy_beats_timeout_retry", int'(retry_count), 0);
    kick = 1'b1; @(negedge clk); kick = 1'b0;
    checki("kick_up_state", int'(sup_state), 4);
    checki("kick_up_relink", int'(relink_pulse), 1);
    @(negedge clk);
    checki("kick_up_relink_single", int'(relink_pulse), 0);
    wait_state(3'd1, 40, "s4_hold");
    @(negedge clk); en = 1'b0; @(negedge clk);
    checki("en_off_state", int'(sup_state), 0);
    checki("en_off_ctrl_reset", int'(ctrl_reset), 1);
    en = 1'b1;

    // Randomized traffic checked cycle by cycle against the model
    rdy_lvl = 1'b1; burst = 0;
    for (int c = 0; c < 5000; c++) begin
      rst  = ($urandom_range(0, 599) == 0);
      if (en) en = ($urandom_range(0, 299) != 0);
      else    en = ($urandom_range(0, 7) == 0);
      kick = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 59) == 0) rdy_lvl = ~rdy_lvl;
      txr = rdy_lvl && ($urandom_range(0, 199) != 0);
      rxr = rdy_lvl && ($urandom_range(0, 199) != 0);
      if (burst > 0) begin
        lock = 1'b0; burst--;
      end else begin
        lock = 1'b1;
        if ($urandom_range(0, 99) == 0) burst = $urandom_range(1, 14);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
